// File: rtl/text_pkg.sv
// Shared constants, cell layout and FSM state type for the text tile renderer.
package text_pkg;

  localparam int TILE_W  = 32;
  localparam int TILE_H  = 64;
  localparam int CHAR_W  = 7;
  localparam int COLOR_W = 3;
  localparam int CELL_W  = CHAR_W + COLOR_W;

  localparam logic [CHAR_W-1:0]  CLR_CHAR  = 7'h20;
  localparam logic [COLOR_W-1:0] CLR_COLOR = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [CHAR_W-1:0]  ch;
    logic [COLOR_W-1:0] color;
  } cell_t;

  function automatic cell_t make_cell(input logic [CHAR_W-1:0] ch,
                                      input logic [COLOR_W-1:0] color);
    cell_t c;
    c.ch    = ch;
    c.color = color;
    return c;
  endfunction

endpackage

// File: rtl/text_char_buffer.sv
// Tile cell store: one write port, one registered read port, write-first on address collision.
module text_char_buffer
  import text_pkg::*;
#(
  parameter int DEPTH = 140,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  cell_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output cell_t         rdata_o
);

  cell_t mem_q [DEPTH];
  cell_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Forward the write data so a same-cycle write is visible on the read port.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_tile_renderer.sv
// Text overlay renderer: 3-stage pixel pipeline over a tile cell buffer plus a clear sweeper.
// Cursor blinking is built only when TEXT_CURSOR_BLINK_EN is defined.
module text_tile_renderer
  import text_pkg::*;
#(
  parameter int COLS         = 20,
  parameter int ROWS         = 7,
  parameter int X0           = 1,
  parameter int Y0           = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [9:0]          pix_x_i,
  input  logic [9:0]          pix_y_i,
  input  logic                frame_tick_i,
  input  logic                wr_valid_i,
  input  logic [4:0]          wr_col_i,
  input  logic [3:0]          wr_row_i,
  input  logic [CHAR_W-1:0]   wr_char_i,
  input  logic [COLOR_W-1:0]  wr_color_i,
  output logic                wr_ready_o,
  input  logic                clr_i,
  output logic                busy_o,
  input  logic [4:0]          cursor_col_i,
  input  logic [3:0]          cursor_row_i,
  output logic [12:0]         font_addr_o,
  input  logic [31:0]         font_data_i,
  output logic [COLOR_W-1:0]  text_rgb_o,
  output logic                text_on_o
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BIT_W = $clog2(TILE_W);
  localparam int ROW_W = $clog2(TILE_H);

  // ---------------------------------------------------------------
  // Window test: a wrapped subtraction turns "lo <= t <= hi" into one compare.
  // ---------------------------------------------------------------
  logic [6:0]    x_rel;
  logic [5:0]    y_rel;
  logic [4:0]    rel_col;
  logic [3:0]    rel_row;
  logic          in_win;
  logic [AW-1:0] rd_addr;

  assign x_rel   = {2'b00, pix_x_i[9:5]} - 7'(X0);
  assign y_rel   = {2'b00, pix_y_i[9:6]} - 6'(Y0);
  assign rel_col = x_rel[4:0];
  assign rel_row = y_rel[3:0];
  assign in_win  = (x_rel < 7'(COLS)) && (y_rel < 6'(ROWS));
  assign rd_addr = in_win ? (AW'(rel_row) * AW'(COLS) + AW'(rel_col)) : '0;

  // ---------------------------------------------------------------
  // Cursor blink
  // ---------------------------------------------------------------
  logic cursor_hit;
  logic blink_on;

`ifdef TEXT_CURSOR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick_i) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign cursor_hit = in_win && (rel_col == cursor_col_i) && (rel_row == cursor_row_i);
  assign blink_on   = blink_phase_q;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col_i, cursor_row_i, frame_tick_i, BLINK_FRAMES[0]};
  assign cursor_hit    = 1'b0;
  assign blink_on      = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Write / clear FSM
  // ---------------------------------------------------------------
  state_e        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  cell_t         buf_wdata;
  cell_t         rd_cell;

  assign wr_in_range = ({1'b0, wr_col_i} < 6'(COLS)) && ({1'b0, wr_row_i} < 5'(ROWS));
  assign wr_addr     = AW'(wr_row_i) * AW'(COLS) + AW'(wr_col_i);
  // Held low during reset even though the state register already reads IDLE.
  assign wr_ready_o  = (state_q == ST_IDLE) && rst_ni;
  assign busy_o      = (state_q == ST_CLEAR);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    buf_we    = 1'b0;
    buf_waddr = wr_addr;
    buf_wdata = make_cell(wr_char_i, wr_color_i);
    case (state_q)
      ST_IDLE: begin
        if (wr_valid_i && wr_ready_o && wr_in_range) begin
          buf_we = 1'b1;
        end
        if (clr_i && wr_ready_o) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        buf_we    = 1'b1;
        buf_waddr = clr_idx_q;
        buf_wdata = make_cell(CLR_CHAR, CLR_COLOR);
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  text_char_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (buf_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_cell)
  );

  // ---------------------------------------------------------------
  // Pixel pipeline: cell read -> font read -> output register
  // ---------------------------------------------------------------
  logic               s1_win_q, s2_win_q;
  logic               s1_hit_q, s2_hit_q;
  logic [BIT_W-1:0]   s1_bit_q, s2_bit_q;
  logic [ROW_W-1:0]   s1_yrow_q;
  logic [COLOR_W-1:0] s2_color_q;
  logic               text_on_q;
  logic [COLOR_W-1:0] text_rgb_q;
  logic               font_bit;

  assign font_addr_o = {rd_cell.ch, s1_yrow_q};
  assign font_bit    = font_data_i[~s2_bit_q] ^ (blink_on && s2_hit_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_win_q   <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_bit_q   <= '0;
      s1_yrow_q  <= '0;
      s2_win_q   <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_bit_q   <= '0;
      s2_color_q <= '0;
      text_on_q  <= 1'b0;
      text_rgb_q <= '0;
    end else begin
      s1_win_q   <= in_win;
      s1_hit_q   <= cursor_hit;
      s1_bit_q   <= pix_x_i[BIT_W-1:0];
      s1_yrow_q  <= pix_y_i[ROW_W-1:0];
      s2_win_q   <= s1_win_q;
      s2_hit_q   <= s1_hit_q;
      s2_bit_q   <= s1_bit_q;
      s2_color_q <= rd_cell.color;
      text_on_q  <= s2_win_q;
      text_rgb_q <= (s2_win_q && font_bit) ? s2_color_q : '0;
    end
  end

  assign text_on_o  = text_on_q;
  assign text_rgb_o = text_rgb_q;

endmodule

// File: doc/text_tile_renderer.md
TEXT_TILE_RENDERER -- requirements
Module: text_tile_renderer

Interface
REQ-001 SHALL have parameter COLS, default 20, text columns (tiles of 32x64 px).
REQ-002 SHALL have parameter ROWS, default 7, text rows.
REQ-003 SHALL have parameter X0, default 1, first tile column (pix_x[9:5] units).
REQ-004 SHALL have parameter Y0, default 0, first tile row (pix_y[9:6] units).
REQ-005 SHALL have parameter BLINK_FRAMES, default 30, frames per cursor blink half-period.
REQ-006 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports pix_x_i and pix_y_i, input, 10 each, current pixel position.
REQ-009 SHALL have port frame_tick_i, input, 1, one-cycle pulse per frame.
REQ-010 SHALL have ports wr_valid_i (1), wr_col_i (5), wr_row_i (4), wr_char_i (7) and wr_color_i (3), all inputs, forming the cell write request.
REQ-011 SHALL have port wr_ready_o, output, 1, write accepted when wr_valid_i and wr_ready_o are both high.
REQ-012 SHALL have ports clr_i (input, 1, start clear) and busy_o (output, 1, clear in progress).
REQ-013 SHALL have ports cursor_col_i (5) and cursor_row_i (4), inputs, cursor cell.
REQ-014 SHALL have ports font_addr_o (output, 13, {char,row}) and font_data_i (input, 32), connecting to font_rom with 1-cycle read latency.
REQ-015 SHALL have ports text_rgb_o (output, 3) and text_on_o (output, 1), pixel colour and overlay-active flag.

Function
REQ-016 SHALL hold one 10-bit cell per tile position: 7-bit char code and 3-bit colour, COLS*ROWS cells.
REQ-017 SHALL set in-window to pix_x[9:5] in [X0, X0+COLS-1] and pix_y[9:6] in [Y0, Y0+ROWS-1].
REQ-018 SHALL compute font_addr_o = {cell char, pix_y[5:0]} and select font bit font_data_i[~pix_x[4:0]] (MSB = leftmost).
REQ-019 SHALL be a 3-stage pipeline: stage 1 reads the cell buffer, stage 2 issues the font ROM read, stage 3 registers the outputs. Total latency from pix_x_i/pix_y_i to text_rgb_o/text_on_o is exactly 3 cycles.
REQ-020 SHALL delay bit index, in-window and cursor-hit flags alongside the data so they stay cycle-aligned with it.
REQ-021 SHALL output text_on_o = delayed in-window; text_rgb_o = cell colour when font bit is 1, else 3'b000; 3'b000 when out of window.
REQ-022 SHALL use an FSM with states IDLE and CLEAR; busy_o = (state == CLEAR); wr_ready_o = (state == IDLE).
REQ-023 SHALL, on clr_i in IDLE, enter CLEAR and write char 7'h20 with colour 3'b111 to one cell per cycle, linear index 0..COLS*ROWS-1, then return to IDLE.
REQ-024 SHALL ignore clr_i asserted during CLEAR; the sweep is not restarted.
REQ-025 SHALL, on an accepted write with wr_col_i >= COLS or wr_row_i >= ROWS, drop the write and leave every cell unchanged.
REQ-026 SHALL give a write to the cell currently being read the new value from the next cycle on (write-first).
REQ-027 SHALL, when clr_i and wr_valid_i arrive in the same IDLE cycle, accept the write first and then start the clear on that same edge.

Reset
REQ-028 SHALL, while rst_ni is low, force text_rgb_o=0, text_on_o=0, busy_o=0, wr_ready_o=0, FSM=IDLE, blink counter=0, blink phase=0 and all pipeline valid flags=0.
REQ-029 SHALL leave cell contents undefined after reset; software issues clr_i.
REQ-030 SHALL, on reset during CLEAR, abort the sweep; wr_ready_o goes high in the first cycle after rst_ni rises.

Configuration
REQ-031 SHALL, with macro TEXT_CURSOR_BLINK_EN defined, count frame_tick_i pulses modulo BLINK_FRAMES and toggle the blink phase at each wrap.
REQ-032 SHALL, with TEXT_CURSOR_BLINK_EN defined and blink phase 1, invert the font bit in the cursor cell, so the whole tile shows the cell colour where glyph pixels are off.
REQ-033 SHALL, without TEXT_CURSOR_BLINK_EN, keep the cursor ports and frame_tick_i but ignore them; no counter is implemented.

Structure
REQ-034 SHALL place TILE_W=32, TILE_H=64, CHAR_W=7, COLOR_W=3 and the FSM state enum in shared package text_pkg.
REQ-035 SHALL implement the cell store as sub-module text_char_buffer (1 write port, 1 registered read port).
REQ-036 SHALL keep font_rom outside the block; it is connected at top level.

Verification
REQ-037 SHALL verify: reset, clr_i, wait until busy_o=0 (140 cycles at defaults) -> text_on_o=1 for every in-window pixel and text_rgb_o=0 for char 0x20.
REQ-038 SHALL verify: write col 0, row 0, char 0x41, colour 3'b001; scan pixel (32,0)..(63,63) -> rgb 001 exactly where font 0x41 bits are 1, 3 cycles late.
REQ-039 SHALL verify: write with col 25 at defaults -> no cell changes; wr_ready_o stays 1.
REQ-040 SHALL verify: pix_x=31 then 32 -> text_on_o goes 0 then 1 at cycles 3 and 4.
REQ-041 SHALL verify: with TEXT_CURSOR_BLINK_EN, cursor (0,0), 30 frame_tick_i pulses -> cursor tile inverted; 30 more pulses -> normal.
REQ-042 SHALL verify: rst_ni low at clear index 50 -> busy_o=0 and wr_ready_o=1 in the first cycle after release.
